// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART peripheral.
//   eUartState     : TX/RX serialiser states
//   ADR_DATA/STATUS: one-bit register select values on wb_adr
//   ST_*           : bit positions inside the STATUS register
package pUart;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } eUartState;

    localparam logic ADR_DATA   = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_RXV   = 4;

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// mFifo: small synchronous FIFO with show-ahead read data.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and data (ignored when full unless popping)
//   pop, pop_data     : read request; pop_data always shows the head entry
//   full, empty       : status from the extra-MSB pointer compare
module mFifo #(
    parameter int nWidth = 8,
    parameter int nDepth = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [nWidth-1:0] push_data,
    input  logic              pop,
    output logic [nWidth-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(nDepth);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [nWidth-1:0] mem_reg [nDepth];
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign pop_data = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone slave that queues bytes in a FIFO and sends them 8N1,
// LSB first, on uart_tx.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wb_stb, wb_we, wb_adr : bus request (adr 0 = DATA, 1 = STATUS)
//   wb_dat_i / wb_dat_o   : write / read data (read data valid with wb_ack)
//   wb_ack                : registered single-cycle acknowledge
//   uart_tx               : serial output, idle high
//   uart_rx               : serial input, used only when UART_RX_EN is defined
// Optional feature macro: UART_RX_EN (adds an 8N1 receiver with a 1-byte holding register).
module wb_uart_tx
    import pUart::*;
#(
    parameter int nTicksPerBaud = 4,
    parameter int nDepth        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wb_stb,
    input  logic       wb_we,
    input  logic       wb_adr,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack,
    output logic       uart_tx,
    input  logic       uart_rx
);

    localparam int BW = $clog2(nTicksPerBaud);
    localparam logic [BW-1:0] BAUD_LAST = BW'(nTicksPerBaud - 1);
    localparam logic [BW-1:0] BAUD_ONE  = {{(BW-1){1'b0}}, 1'b1};

    // ---------------- bus side ----------------
    logic       wb_ack_reg;
    logic [7:0] wb_dat_o_reg, wb_dat_o_next;
    logic       overflow_reg, overflow_next;
    logic       access, wr_data, rd_status, rd_data_acc;
    logic [7:0] status_vec;
    logic       rx_valid;
    logic [7:0] rx_byte;

    // An access is taken on the edge that raises ack; a held strobe therefore
    // produces one transfer every other cycle.
    assign access      = wb_stb && !wb_ack_reg;
    assign wr_data     = access &&  wb_we && (wb_adr == ADR_DATA);
    assign rd_status   = access && !wb_we && (wb_adr == ADR_STATUS);
    assign rd_data_acc = access && !wb_we && (wb_adr == ADR_DATA);

    // ---------------- FIFO ----------------
    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    mFifo #(.nWidth(8), .nDepth(nDepth)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_data),
        .push_data (wb_dat_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- TX FSM ----------------
    eUartState  state_reg, state_next;
    logic [BW-1:0] baud_reg, baud_next;
    logic [2:0] idx_reg, idx_next;
    logic [7:0] shift_reg, shift_next;
    logic       tx_reg, tx_next;
    logic       tick;

    assign tick = (baud_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    baud_next  = BAUD_LAST;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    baud_next  = BAUD_LAST;
                    idx_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - BAUD_ONE;
                end
            end
            DATA: begin
                if (tick) begin
                    baud_next  = BAUD_LAST;
                    shift_next = shift_reg >> 1;
                    idx_next   = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) state_next = STOP;
                end else begin
                    baud_next = baud_reg - BAUD_ONE;
                end
            end
            STOP: begin
                if (tick) begin
                    // Back-to-back frames: reload straight into START.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        baud_next  = BAUD_LAST;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg - BAUD_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is decoded from the next state so uart_tx leaves a flop.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign uart_tx = tx_reg;

    // ---------------- optional receiver ----------------
`ifdef UART_RX_EN
    localparam logic [BW-1:0] BAUD_HALF = BW'(nTicksPerBaud / 2 - 1);

    logic [1:0]    rx_sync_reg;
    eUartState     rx_state_reg, rx_state_next;
    logic [BW-1:0] rx_baud_reg, rx_baud_next;
    logic [2:0]    rx_idx_reg, rx_idx_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic [7:0]    rx_hold_reg, rx_hold_next;
    logic          rx_valid_reg, rx_valid_next;
    logic          rx_s, rx_tick;

    assign rx_s    = rx_sync_reg[1];
    assign rx_tick = (rx_baud_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_reg  <= 2'b11;
            rx_state_reg <= IDLE;
            rx_baud_reg  <= '0;
            rx_idx_reg   <= '0;
            rx_shift_reg <= '0;
            rx_hold_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[0], uart_rx};
            rx_state_reg <= rx_state_next;
            rx_baud_reg  <= rx_baud_next;
            rx_idx_reg   <= rx_idx_next;
            rx_shift_reg <= rx_shift_next;
            rx_hold_reg  <= rx_hold_next;
            rx_valid_reg <= rx_valid_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_baud_next  = rx_baud_reg;
        rx_idx_next   = rx_idx_reg;
        rx_shift_next = rx_shift_reg;
        rx_hold_next  = rx_hold_reg;
        // A byte landing in the same cycle as a DATA read wins over the clear.
        rx_valid_next = rx_valid_reg && !rd_data_acc;
        case (rx_state_reg)
            IDLE: begin
                if (!rx_s) begin
                    rx_baud_next  = BAUD_HALF;
                    rx_state_next = START;
                end
            end
            START: begin
                if (rx_tick) begin
                    // Re-check the start bit at mid-bit to reject glitches.
                    if (!rx_s) begin
                        rx_baud_next  = BAUD_LAST;
                        rx_idx_next   = 3'd0;
                        rx_state_next = DATA;
                    end else begin
                        rx_state_next = IDLE;
                    end
                end else begin
                    rx_baud_next = rx_baud_reg - BAUD_ONE;
                end
            end
            DATA: begin
                if (rx_tick) begin
                    rx_baud_next  = BAUD_LAST;
                    rx_shift_next = {rx_s, rx_shift_reg[7:1]};
                    rx_idx_next   = rx_idx_reg + 3'd1;
                    if (rx_idx_reg == 3'd7) rx_state_next = STOP;
                end else begin
                    rx_baud_next = rx_baud_reg - BAUD_ONE;
                end
            end
            STOP: begin
                if (rx_tick) begin
                    if (rx_s) begin
                        rx_hold_next  = rx_shift_reg;
                        rx_valid_next = 1'b1;
                    end
                    rx_state_next = IDLE;
                end else begin
                    rx_baud_next = rx_baud_reg - BAUD_ONE;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    assign rx_valid = rx_valid_reg;
    assign rx_byte  = rx_hold_reg;
`else
    logic unused_rx;
    assign unused_rx = uart_rx;
    assign rx_valid  = 1'b0;
    assign rx_byte   = 8'h00;
`endif

    // ---------------- registers / read path ----------------
    always_comb begin
        status_vec           = 8'h00;
        status_vec[ST_FULL]  = fifo_full;
        status_vec[ST_EMPTY] = fifo_empty;
        status_vec[ST_BUSY]  = (state_reg != IDLE) || !fifo_empty;
        status_vec[ST_OVF]   = overflow_reg;
        status_vec[ST_RXV]   = rx_valid;
    end

    always_comb begin
        wb_dat_o_next = 8'h00;
        if (rd_status)        wb_dat_o_next = status_vec;
        else if (rd_data_acc) wb_dat_o_next = rx_byte;
    end

    // Set beats clear when a dropped write coincides with a STATUS read.
    always_comb begin
        overflow_next = overflow_reg;
        if (rd_status) overflow_next = 1'b0;
        if (wr_data && fifo_full && !fifo_pop) overflow_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_reg   <= 1'b0;
            wb_dat_o_reg <= 8'h00;
            overflow_reg <= 1'b0;
        end else begin
            wb_ack_reg   <= access;
            wb_dat_o_reg <= wb_dat_o_next;
            overflow_reg <= overflow_next;
        end
    end

    assign wb_ack   = wb_ack_reg;
    assign wb_dat_o = wb_dat_o_reg;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx (nTicksPerBaud = 4, nDepth = 4).
// Register accesses come from a vector table; frame timing, FIFO overflow and
// reset-mid-frame are hand-written sequences checked against a line log.
module tb_wb_uart_tx;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       wb_stb   = 1'b0;
    logic       wb_we    = 1'b0;
    logic       wb_adr   = 1'b0;
    logic [7:0] wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_ack;
    logic       uart_tx;
    logic       uart_rx  = 1'b1;

    wb_uart_tx #(.nTicksPerBaud(4), .nDepth(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack   (wb_ack),
        .uart_tx  (uart_tx),
        .uart_rx  (uart_rx)
    );

    always #5 clk = ~clk;

    // cyc counts posedges; the line is logged at every negedge under that count.
    int   cyc = 0;
    logic tx_log [4096];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 4096) tx_log[cyc] <= uart_tx;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       we;
        logic       adr;
        logic [7:0] wdat;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Call at a negedge. Returns read data and the posedge count of the acking edge.
    task automatic xfer(input logic we, input logic adr, input logic [7:0] wdat,
                        output logic [7:0] rdat, output int acyc);
        logic ok;
        ok = 1'b0;
        wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdat;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                ok = 1'b1;
                break;
            end
        end
        rdat = wb_dat_o;
        acyc = cyc;
        wb_stb = 1'b0;
        $display("xfer cyc=%0d we=%0d adr=%0d wdat=%h rdat=%h ack=%0d", acyc, we, adr, wdat, rdat, ok);
        chk("ack_seen", ok, 1'b1);
        @(negedge clk);
        chk("ack_one_cycle", wb_ack, 1'b0);
    endtask

    function automatic logic [39:0] frame_exp(input logic [7:0] b);
        logic [39:0] f;
        for (int t = 0; t < 40; t++) begin
            if (t < 4)       f[t] = 1'b0;
            else if (t < 36) f[t] = b[(t - 4) / 4];
            else             f[t] = 1'b1;
        end
        return f;
    endfunction

    task automatic chk_frame(input string name, input int start, input logic [7:0] b);
        logic [39:0] act;
        wait_cyc(start + 40);
        for (int t = 0; t < 40; t++) act[t] = tx_log[start + t];
        chk(name, act, frame_exp(b));
    endtask

    task automatic chk_idle(input string name, input int from, input int n);
        int zeros;
        zeros = 0;
        wait_cyc(from + n);
        for (int t = 0; t < n; t++) if (tx_log[from + t] !== 1'b1) zeros++;
        chk(name, zeros, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cyc=%0d expected < 20000", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int         ac;
        int         start;
        logic [7:0] b3 [3];
        logic [7:0] b6 [6];

        vecs[0] = '{we: 1'b0, adr: 1'b1, wdat: 8'h00, exp: 8'h02};
        vecs[1] = '{we: 1'b0, adr: 1'b0, wdat: 8'h00, exp: 8'h00};
        vecs[2] = '{we: 1'b1, adr: 1'b1, wdat: 8'hFF, exp: 8'h00};
        vecs[3] = '{we: 1'b0, adr: 1'b1, wdat: 8'h00, exp: 8'h02};
        b3 = '{8'hA1, 8'hB2, 8'hC3};
        b6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_ack", wb_ack, 1'b0);
        chk("rst_dat_o", wb_dat_o, 8'h00);
        rst_n = 1'b1;

        // Test 1: register table
        for (int i = 0; i < 4; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, rd, ac);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end
        chk_idle("t1_line_idle", 1, cyc - 1);

        // Test 2: single frame 0x55
        xfer(1'b1, 1'b0, 8'h55, rd, ac);
        start = ac + 1;
        xfer(1'b0, 1'b1, 8'h00, rd, ac);
        chk("t2_status_busy", rd, 8'h06);
        chk_frame("t2_frame_55", start, 8'h55);
        chk_idle("t2_idle_after", start + 40, 8);

        // Test 3: three back-to-back frames
        xfer(1'b1, 1'b0, b3[0], rd, ac);
        start = ac + 1;
        xfer(1'b1, 1'b0, b3[1], rd, ac);
        xfer(1'b1, 1'b0, b3[2], rd, ac);
        for (int f = 0; f < 3; f++) chk_frame($sformatf("t3_frame%0d", f), start + 40 * f, b3[f]);
        chk_idle("t3_idle_after", start + 120, 8);
        xfer(1'b0, 1'b1, 8'h00, rd, ac);
        chk("t3_status_end", rd, 8'h02);

        // Test 4: overflow
        xfer(1'b1, 1'b0, b6[0], rd, ac);
        start = ac + 1;
        for (int i = 1; i < 6; i++) xfer(1'b1, 1'b0, b6[i], rd, ac);
        xfer(1'b0, 1'b1, 8'h00, rd, ac);
        chk("t4_status_ovf", rd, 8'h0D);
        xfer(1'b0, 1'b1, 8'h00, rd, ac);
        chk("t4_status_reread", rd, 8'h05);
        for (int f = 0; f < 5; f++) chk_frame($sformatf("t4_frame%0d", f), start + 40 * f, b6[f]);
        chk_idle("t4_no_sixth_frame", start + 200, 48);
        xfer(1'b0, 1'b1, 8'h00, rd, ac);
        chk("t4_status_end", rd, 8'h02);

        // Test 5: reset mid-DATA discards current and queued bytes
        xfer(1'b1, 1'b0, 8'h00, rd, ac);
        start = ac + 1;
        xfer(1'b1, 1'b0, 8'h0F, rd, ac);
        xfer(1'b1, 1'b0, 8'hF0, rd, ac);
        wait_cyc(start + 12);
        chk("t5_pre_rst_low", uart_tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx_high", uart_tx, 1'b1);
        chk("t5_rst_ack_low", wb_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 1'b1, 8'h00, rd, ac);
        chk("t5_status_after", rd, 8'h02);
        chk_idle("t5_no_residual", ac, 60);

`ifdef UART_RX_EN
        // Test 6: receive 0x3C
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'h3C, 1'b0};
            for (int i = 0; i < 10; i++) begin
                uart_rx = fr[i];
                repeat (4) @(negedge clk);
            end
            repeat (6) @(negedge clk);
            xfer(1'b0, 1'b1, 8'h00, rd, ac);
            chk("t6_status_rxv", rd, 8'h12);
            xfer(1'b0, 1'b0, 8'h00, rd, ac);
            chk("t6_rx_data", rd, 8'h3C);
            xfer(1'b0, 1'b1, 8'h00, rd, ac);
            chk("t6_status_clr", rd, 8'h02);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
